// File: rtl/axilite_timer.sv
// AXI4-Lite RISC-V machine timer: 64-bit mtime, 64-bit mtimecmp, CTRL and a
// registered level interrupt. Define AXI_TIMER_PRESCALE_EN to add the PRESCALE
// register at 0x14 and a prescaled mtime tick.
module axilite_timer #(
    parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int unsigned DECODE_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        timer_irq_o
);

    // Word index width: addr[1:0] are ignored.
    localparam int unsigned IW = DECODE_BITS - 2;

    localparam logic [IW-1:0] IdxMtimeLo = IW'(0);
    localparam logic [IW-1:0] IdxMtimeHi = IW'(1);
    localparam logic [IW-1:0] IdxCmpLo   = IW'(2);
    localparam logic [IW-1:0] IdxCmpHi   = IW'(3);
    localparam logic [IW-1:0] IdxCtrl    = IW'(4);
`ifdef AXI_TIMER_PRESCALE_EN
    localparam logic [IW-1:0] IdxPresc   = IW'(5);
`endif

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    // Byte-strobe merge of a 32-bit register word.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // State
    logic          aw_full_q, aw_full_d;
    logic [IW-1:0] awidx_q, awidx_d;
    logic          w_full_q, w_full_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          en_q, en_d;
    logic          irq_en_q, irq_en_d;
    logic [31:0]   hi_shadow_q, hi_shadow_d;
    logic          irq_q, irq_d;
`ifdef AXI_TIMER_PRESCALE_EN
    logic [15:0]   presc_q, presc_d;
    logic [15:0]   pcnt_q, pcnt_d;
`endif

    // Handshakes and the effective (latched or in-flight) write beat
    logic          aw_hs, w_hs, ar_hs, wr_commit;
    logic [IW-1:0] wr_idx, ar_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl, wr_mapped;
    logic          tick;
`ifdef AXI_TIMER_PRESCALE_EN
    logic          wr_pre;
`endif

    // Address bits above the decode window, addr[1:0] and prot are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[31:DECODE_BITS], axi_awaddr[1:0],
                           axi_araddr[31:DECODE_BITS], axi_araddr[1:0]};

    assign axi_awready = !aw_full_q && !bvalid_q;
    assign axi_wready  = !w_full_q && !bvalid_q;
    assign axi_arready = !rvalid_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign timer_irq_o = irq_q;

    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign ar_hs  = axi_arvalid && axi_arready;
    assign ar_idx = axi_araddr[DECODE_BITS-1:2];

    // Commit on the same edge as the later handshake so bvalid lands one cycle after it.
    assign wr_commit = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;
    assign wr_idx    = aw_full_q ? awidx_q : axi_awaddr[DECODE_BITS-1:2];
    assign wr_data   = w_full_q ? wdata_q : axi_wdata;
    assign wr_strb   = w_full_q ? wstrb_q : axi_wstrb;

    // Write address decode
    always_comb begin
        wr_mlo  = wr_commit && (wr_idx == IdxMtimeLo);
        wr_mhi  = wr_commit && (wr_idx == IdxMtimeHi);
        wr_clo  = wr_commit && (wr_idx == IdxCmpLo);
        wr_chi  = wr_commit && (wr_idx == IdxCmpHi);
        wr_ctrl = wr_commit && (wr_idx == IdxCtrl);
`ifdef AXI_TIMER_PRESCALE_EN
        wr_pre    = wr_commit && (wr_idx == IdxPresc);
        wr_mapped = wr_mlo || wr_mhi || wr_clo || wr_chi || wr_ctrl || wr_pre;
`else
        wr_mapped = wr_mlo || wr_mhi || wr_clo || wr_chi || wr_ctrl;
`endif
    end

    // Write channel bookkeeping and response
    always_comb begin
        aw_full_d = aw_full_q;
        awidx_d   = awidx_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            awidx_d   = axi_awaddr[DECODE_BITS-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = axi_wdata;
            wstrb_d  = axi_wstrb;
        end
        if (wr_commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_mapped ? RespOkay : RespSlvErr;
        end else if (bvalid_q && axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read channel: data comes from pre-edge register state
    always_comb begin
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        hi_shadow_d = hi_shadow_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = 32'h0;
            rresp_d  = RespOkay;
            case (ar_idx)
                IdxMtimeLo: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                IdxMtimeHi: rdata_d = hi_shadow_q;
                IdxCmpLo:   rdata_d = mtimecmp_q[31:0];
                IdxCmpHi:   rdata_d = mtimecmp_q[63:32];
                IdxCtrl:    rdata_d = {30'h0, irq_en_q, en_q};
`ifdef AXI_TIMER_PRESCALE_EN
                IdxPresc:   rdata_d = {16'h0, presc_q};
`endif
                default:    rresp_d = RespSlvErr;
            endcase
        end else if (rvalid_q && axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Counter, comparator, control and interrupt next state
    always_comb begin
`ifdef AXI_TIMER_PRESCALE_EN
        tick    = en_q && (pcnt_q == presc_q);
        pcnt_d  = en_q ? (tick ? 16'h0 : pcnt_q + 16'h1) : pcnt_q;
        presc_d = presc_q;
        if (wr_pre) begin
            presc_d[7:0]  = wr_strb[0] ? wr_data[7:0]  : presc_q[7:0];
            presc_d[15:8] = wr_strb[1] ? wr_data[15:8] : presc_q[15:8];
        end
        if (wr_mlo || wr_mhi || wr_pre) begin
            pcnt_d = 16'h0;
        end
`else
        tick = en_q;
`endif
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        // A software write to mtime wins over the increment on that edge.
        if (wr_mlo) begin
            mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strb)};
        end
        if (wr_mhi) begin
            mtime_d = {merge(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        end
        mtimecmp_d = mtimecmp_q;
        if (wr_clo) begin
            mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], wr_data, wr_strb);
        end
        if (wr_chi) begin
            mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wr_data, wr_strb);
        end
        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl && wr_strb[0]) begin
            en_d     = wr_data[0];
            irq_en_d = wr_data[1];
        end
        irq_d = irq_en_q && (mtime_q >= mtimecmp_q);
    end

    // All state registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q   <= 1'b0;
            awidx_q     <= '0;
            w_full_q    <= 1'b0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RespOkay;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            rresp_q     <= RespOkay;
            mtime_q     <= 64'h0;
            mtimecmp_q  <= CMP_RESET;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            hi_shadow_q <= 32'h0;
            irq_q       <= 1'b0;
`ifdef AXI_TIMER_PRESCALE_EN
            presc_q     <= 16'h0;
            pcnt_q      <= 16'h0;
`endif
        end else begin
            aw_full_q   <= aw_full_d;
            awidx_q     <= awidx_d;
            w_full_q    <= w_full_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            hi_shadow_q <= hi_shadow_d;
            irq_q       <= irq_d;
`ifdef AXI_TIMER_PRESCALE_EN
            presc_q     <= presc_d;
            pcnt_q      <= pcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axilite_timer.sv
// Self-checking bench for axilite_timer: register-access vector table plus
// directed sequences for latency, carry, interrupt, collision and reset cases.
module tb_axilite_timer;

    localparam int Timeout = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_awaddr = 32'h0;
    logic [2:0]  axi_awprot = 3'h0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [31:0] axi_wdata = 32'h0;
    logic [3:0]  axi_wstrb = 4'h0;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_araddr = 32'h0;
    logic [2:0]  axi_arprot = 3'h0;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        timer_irq_o;

    int checks = 0;
    int errors = 0;
    logic irq_at_b;

    axilite_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_awaddr (axi_awaddr),
        .axi_awprot (axi_awprot),
        .axi_wvalid (axi_wvalid),
        .axi_wready (axi_wready),
        .axi_wdata  (axi_wdata),
        .axi_wstrb  (axi_wstrb),
        .axi_bvalid (axi_bvalid),
        .axi_bready (axi_bready),
        .axi_bresp  (axi_bresp),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_araddr (axi_araddr),
        .axi_arprot (axi_arprot),
        .axi_rvalid (axi_rvalid),
        .axi_rready (axi_rready),
        .axi_rdata  (axi_rdata),
        .axi_rresp  (axi_rresp),
        .timer_irq_o(timer_irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [31:0] act, input logic [31:0] lo,
                             input logic [31:0] hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock step; all driving and sampling happens 1 time unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bit aw_go, w_go;
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        n = 0;
        while ((axi_awvalid || axi_wvalid) && n < Timeout) begin
            aw_go = axi_awvalid && axi_awready;
            w_go  = axi_wvalid && axi_wready;
            step();
            if (aw_go) axi_awvalid = 1'b0;
            if (w_go) axi_wvalid = 1'b0;
            n++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        n = 0;
        while (!axi_bvalid && n < Timeout) begin
            step();
            n++;
        end
        check("write_bvalid", axi_bvalid, 1);
        resp     = axi_bresp;
        irq_at_b = timer_irq_o;
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        bit go;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        n = 0;
        while (axi_arvalid && n < Timeout) begin
            go = axi_arready;
            step();
            if (go) axi_arvalid = 1'b0;
            n++;
        end
        axi_arvalid = 1'b0;
        n = 0;
        while (!axi_rvalid && n < Timeout) begin
            step();
            n++;
        end
        check("read_rvalid", axi_rvalid, 1);
        data = axi_rdata;
        resp = axi_rresp;
        axi_rready = 1'b1;
        step();
        axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, v1, v2;
        logic [1:0]  r;
        int          cnt;

        // addr, data, strb, expected rdata, expected resp (reads) / bresp (writes)
        vecs[0]  = '{0, 32'h08, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00};
        vecs[1]  = '{0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b00};
        vecs[2]  = '{0, 32'h10, 32'h0, 4'h0, 32'h0, 2'b00};
        vecs[3]  = '{0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00};
        vecs[4]  = '{1, 32'h08, 32'h55, 4'hF, 32'h0, 2'b00};
        vecs[5]  = '{0, 32'h08, 32'h0, 4'h0, 32'h55, 2'b00};
        vecs[6]  = '{1, 32'h0C, 32'h1234_5678, 4'h3, 32'h0, 2'b00};
        vecs[7]  = '{0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_5678, 2'b00};
        vecs[8]  = '{0, 32'h18, 32'h0, 4'h0, 32'h0, 2'b10};
        vecs[9]  = '{1, 32'h1C, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b10};
        vecs[10] = '{1, 32'h03, 32'hAABB_CCDD, 4'h5, 32'h0, 2'b00};
        vecs[11] = '{0, 32'h20, 32'h0, 4'h0, 32'h00BB_00DD, 2'b00};
        vecs[12] = '{0, 32'h04, 32'h0, 4'h0, 32'h0, 2'b00};
        vecs[13] = '{1, 32'h10, 32'hFFFF_FFFE, 4'hF, 32'h0, 2'b00};
        vecs[14] = '{0, 32'h10, 32'h0, 4'h0, 32'h2, 2'b00};
        vecs[15] = '{1, 32'h10, 32'h0, 4'hF, 32'h0, 2'b00};
`ifdef AXI_TIMER_PRESCALE_EN
        vecs[16] = '{0, 32'h14, 32'h0, 4'h0, 32'h0, 2'b00};
`else
        vecs[16] = '{0, 32'h14, 32'h0, 4'h0, 32'h0, 2'b10};
`endif
        vecs[17] = '{0, 32'h08, 32'h0, 4'h0, 32'h55, 2'b00};

        // Reset state
        repeat (3) step();
        check("rst_irq", timer_irq_o, 0);
        check("rst_bvalid", axi_bvalid, 0);
        check("rst_rvalid", axi_rvalid, 0);
        check("rst_rdata", axi_rdata, 0);
        rst_n = 1'b1;
        step();
        check("rst_awready", axi_awready, 1);
        check("rst_wready", axi_wready, 1);
        check("rst_arready", axi_arready, 1);

        // Register access table (EN stays 0 throughout)
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
            end
        end
        check("tbl_irq", timer_irq_o, 0);

        // Split AW / W: AW in cycle 0, W in cycle 3, bvalid in cycle 4, bready held off
        axi_awaddr  = 32'h10;
        axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        check("lat_aw_full", axi_awready, 0);
        check("lat_wready_open", axi_wready, 1);
        step();
        step();
        check("lat_no_b_early", axi_bvalid, 0);
        axi_wdata  = 32'h1;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        check("lat_bvalid", axi_bvalid, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_bvalid", axi_bvalid, 1);
            check("hold_awready", axi_awready, 0);
            check("hold_wready", axi_wready, 0);
        end
        check("hold_bresp", axi_bresp, 2'b00);
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        check("b_cleared", axi_bvalid, 0);
        repeat (10) step();
        axi_read(32'h00, v1, r);
        axi_read(32'h00, v2, r);
        check("mtime_running", v1 >= 32'd10, 1);
        check("mtime_increasing", v2 > v1, 1);

        // Carry from LO into HI and atomic HI read
        axi_write(32'h10, 32'h0, 4'hF, r);
        axi_write(32'h00, 32'hFFFF_FFFE, 4'hF, r);
        axi_write(32'h04, 32'h0, 4'hF, r);
        axi_write(32'h10, 32'h1, 4'hF, r);
        repeat (4) step();
        axi_read(32'h00, v1, r);
        axi_read(32'h04, v2, r);
        check("carry_lo", v1, 32'h3);
        check("carry_hi", v2, 32'h1);

        // Partial-strobe write of MTIME_HI
        axi_write(32'h10, 32'h0, 4'hF, r);
        axi_write(32'h04, 32'hAABB_CCDD, 4'hF, r);
        axi_write(32'h04, 32'h1234_5678, 4'h3, r);
        axi_read(32'h00, v1, r);
        axi_read(32'h04, v2, r);
        check("strb_hi", v2, 32'hAABB_5678);

        // Interrupt rise at mtime == mtimecmp, fall after raising mtimecmp
        axi_write(32'h00, 32'h0, 4'hF, r);
        axi_write(32'h04, 32'h0, 4'hF, r);
        axi_write(32'h0C, 32'h0, 4'hF, r);
        axi_write(32'h08, 32'h20, 4'hF, r);
        axi_write(32'h10, 32'h3, 4'hF, r);
        check("irq_low_start", timer_irq_o, 0);
        cnt = 0;
        while (!timer_irq_o && cnt < 100) begin
            step();
            cnt++;
        end
        check("irq_rise_cycle", cnt, 32);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, r);
        check("irq_at_bvalid", irq_at_b, 1);
        check("irq_fall", timer_irq_o, 0);

        // Same-edge read and write of CTRL: read sees the old value
        axi_araddr  = 32'h10;
        axi_awaddr  = 32'h10;
        axi_wdata   = 32'h1;
        axi_wstrb   = 4'hF;
        axi_arvalid = 1'b1;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        step();
        axi_arvalid = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        check("coll_rvalid", axi_rvalid, 1);
        check("coll_bvalid", axi_bvalid, 1);
        check("coll_old_ctrl", axi_rdata, 32'h3);
        axi_rready = 1'b1;
        axi_bready = 1'b1;
        step();
        axi_rready = 1'b0;
        axi_bready = 1'b0;
        axi_read(32'h10, d, r);
        check("coll_new_ctrl", d, 32'h1);

        // Reset in the middle of a pending write and an unconsumed read
        axi_awaddr  = 32'h08;
        axi_awvalid = 1'b1;
        axi_araddr  = 32'h08;
        axi_arvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        axi_arvalid = 1'b0;
        check("mid_aw_full", axi_awready, 0);
        check("mid_rvalid", axi_rvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_awready", axi_awready, 1);
        check("mid_rst_rvalid", axi_rvalid, 0);
        check("mid_rst_rdata", axi_rdata, 0);
        check("mid_rst_bvalid", axi_bvalid, 0);
        check("mid_rst_irq", timer_irq_o, 0);
        step();
        rst_n = 1'b1;
        step();
        axi_read(32'h08, d, r);
        check("post_rst_cmp_lo", d, 32'hFFFF_FFFF);
        axi_read(32'h10, d, r);
        check("post_rst_ctrl", d, 32'h0);
        axi_read(32'h00, d, r);
        check("post_rst_mtime", d, 32'h0);

`ifdef AXI_TIMER_PRESCALE_EN
        // Prescaled counting: PRESCALE=3 gives one tick every 4 cycles
        axi_write(32'h14, 32'hFFFF_0003, 4'hF, r);
        axi_read(32'h14, d, r);
        check("presc_readback", d, 32'h3);
        axi_write(32'h00, 32'h0, 4'hF, r);
        axi_write(32'h10, 32'h1, 4'hF, r);
        repeat (40) step();
        axi_read(32'h00, d, r);
        check_rng("presc_rate", d, 32'd9, 32'd11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
